// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush/freeze sequencing for the 5-stage core
module pipeline_ctrl #(
    parameter int BOOT_CYCLES = 2,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_stall,
    input  logic             redirect,
    input  logic             mem_busy,
    input  logic             cnt_clear,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic             memwb_write,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] cyc_count,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] freeze_count
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FREEZE = 2'd2
    } state_t;

    localparam logic [3:0] BOOT_LOAD = 4'(BOOT_CYCLES);
    localparam logic [9:0] TMO_MAX   = 10'(MEM_TIMEOUT);

    state_t     state, state_nxt;
    logic [3:0] boot_cnt;
    logic [9:0] tmo_cnt;
    logic       active;
    logic       frozen;
    logic       do_flush;
    logic       do_stall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_write = 1'b0;
        memwb_write = 1'b0;
        case (state)
            ST_RUN, ST_FREEZE: begin
                state_nxt = mem_busy ? ST_FREEZE : ST_RUN;
                if (mem_busy) begin
                    // hazard inputs come from held registers; revisit them after the freeze
                end else if (redirect) begin
                    pc_write    = 1'b1;
                    ifid_write  = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    exmem_write = 1'b1;
                    memwb_write = 1'b1;
                end else if (load_use_stall) begin
                    idex_bubble = 1'b1;
                    exmem_write = 1'b1;
                    memwb_write = 1'b1;
                end else begin
                    pc_write    = 1'b1;
                    ifid_write  = 1'b1;
                    exmem_write = 1'b1;
                    memwb_write = 1'b1;
                end
            end
            default: begin
                // BOOT: hold fetch and drain NOPs through the back end
                if (state != ST_BOOT || boot_cnt <= 4'd1) begin
                    state_nxt = ST_RUN;
                end
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                exmem_write = 1'b1;
                memwb_write = 1'b1;
            end
        endcase
    end

    assign active   = (state == ST_RUN) || (state == ST_FREEZE);
    assign frozen   = active && mem_busy;
    assign do_flush = active && !mem_busy && redirect;
    assign do_stall = active && !mem_busy && !redirect && load_use_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            boot_cnt <= BOOT_LOAD;
        end else if (state == ST_BOOT && boot_cnt > 4'd1) begin
            boot_cnt <= boot_cnt - 4'd1;
        end
    end

    // The flag sets on the same edge the run-length reaches the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt     <= '0;
            mem_timeout <= 1'b0;
        end else if (frozen) begin
            if (tmo_cnt != TMO_MAX) begin
                tmo_cnt <= tmo_cnt + 10'd1;
            end
            if (tmo_cnt + 10'd1 >= TMO_MAX) begin
                mem_timeout <= 1'b1;
            end
        end else begin
            tmo_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_count    <= '0;
            stall_count  <= '0;
            flush_count  <= '0;
            freeze_count <= '0;
        end else if (cnt_clear) begin
            cyc_count    <= '0;
            stall_count  <= '0;
            flush_count  <= '0;
            freeze_count <= '0;
        end else begin
            if (active)   cyc_count    <= sat_inc(cyc_count);
            if (do_stall) stall_count  <= sat_inc(stall_count);
            if (do_flush) flush_count  <= sat_inc(flush_count);
            if (frozen)   freeze_count <= sat_inc(freeze_count);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;

    localparam int BOOT_CYCLES = 2;
    localparam int MEM_TIMEOUT = 64;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             load_use_stall = 1'b0;
    logic             redirect = 1'b0;
    logic             mem_busy = 1'b0;
    logic             cnt_clear = 1'b0;
    logic             pc_write, ifid_write, ifid_flush, idex_bubble;
    logic             exmem_write, memwb_write, mem_timeout;
    logic [CNT_W-1:0] cyc_count, stall_count, flush_count, freeze_count;

    pipeline_ctrl #(
        .BOOT_CYCLES(BOOT_CYCLES),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_use_stall(load_use_stall),
        .redirect      (redirect),
        .mem_busy      (mem_busy),
        .cnt_clear     (cnt_clear),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .ifid_flush    (ifid_flush),
        .idex_bubble   (idex_bubble),
        .exmem_write   (exmem_write),
        .memwb_write   (memwb_write),
        .mem_timeout   (mem_timeout),
        .cyc_count     (cyc_count),
        .stall_count   (stall_count),
        .flush_count   (flush_count),
        .freeze_count  (freeze_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] ctl;
        logic       tmo;
        int         cyc, stl, fl, frz;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   stim_done = 1'b0;

    // reference state: cycles since reset release, event totals, busy run-length
    int m_age = 0;
    int m_cyc = 0, m_stl = 0, m_fl = 0, m_frz = 0;
    int m_run = 0;
    bit m_tmo = 1'b0;

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    // control vector: {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write, memwb_write}
    task automatic step(input bit rst, input bit lus, input bit red, input bit busy, input bit clr);
        exp_t e;
        bit   boot;
        @(posedge clk);
        #1;
        rst_n          = !rst;
        load_use_stall = lus;
        redirect       = red;
        mem_busy       = busy;
        cnt_clear      = clr;
        if (rst) begin
            m_age = 0; m_cyc = 0; m_stl = 0; m_fl = 0; m_frz = 0; m_run = 0; m_tmo = 1'b0;
        end
        boot  = rst || (m_age < BOOT_CYCLES);
        e.tmo = m_tmo;
        e.cyc = m_cyc; e.stl = m_stl; e.fl = m_fl; e.frz = m_frz;
        if (boot)      e.ctl = 6'b001111;
        else if (busy) e.ctl = 6'b000000;
        else if (red)  e.ctl = 6'b111111;
        else if (lus)  e.ctl = 6'b000111;
        else           e.ctl = 6'b110011;
        sb.push_back(e);
        if (!rst) begin
            if (!boot && busy) begin
                m_run++;
                if (m_run >= MEM_TIMEOUT) m_tmo = 1'b1;
            end else begin
                m_run = 0;
            end
            if (clr) begin
                m_cyc = 0; m_stl = 0; m_fl = 0; m_frz = 0;
            end else if (!boot) begin
                m_cyc = sat(m_cyc);
                if (busy)      m_frz = sat(m_frz);
                else if (red)  m_fl  = sat(m_fl);
                else if (lus)  m_stl = sat(m_stl);
            end
            if (m_age < 1000000) m_age++;
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ctl", int'({pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write, memwb_write}), int'(e.ctl));
                chk("mem_timeout", int'(mem_timeout), int'(e.tmo));
                chk("cyc_count", int'(cyc_count), e.cyc);
                chk("stall_count", int'(stall_count), e.stl);
                chk("flush_count", int'(flush_count), e.fl);
                chk("freeze_count", int'(freeze_count), e.frz);
            end
        end
    end

    initial begin : stimulus
        int busy_left = 0;
        step(1, 0, 0, 0, 0);
        repeat (7) step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        repeat (70) step(0, $urandom_range(0, 1), $urandom_range(0, 1), 1, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        repeat (4) step(0, 0, 0, 0, 0);
        repeat (20) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if (busy_left == 0 && $urandom_range(0, 9) == 0)
                busy_left = ($urandom_range(0, 19) == 0) ? $urandom_range(60, 75) : $urandom_range(1, 8);
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                 busy_left > 0, $urandom_range(0, 49) == 0);
            if (busy_left > 0) busy_left--;
        end
        step(0, 0, 0, 0, 0);
        stim_done = 1'b1;
    end

    initial begin : finisher
        wait (stim_done);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d pending expected 0", sb.size());
        $fatal(1, "watchdog expired");
    end

endmodule
